// File: rtl/conv_pkg.sv
// Shared types and constants for the 3x3 convolution accumulator slice.
package conv_pkg;

  localparam int TAPS_DEF = 9;
  localparam int PROD_W   = 8;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  function automatic int sign_pos(input int w);
    return w - 1;
  endfunction

  function automatic int max_mag(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  localparam int PROD_SIGN    = sign_pos(PROD_W);
  localparam int PROD_MAX_MAG = max_mag(PROD_W);

endpackage

// File: rtl/sm_add_sat.sv
// Combinational saturating sign-magnitude adder; a zero result always carries sign 0.
module sm_add_sat
  import conv_pkg::*;
#(
  parameter int W = 12
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         overflow
);

  localparam int M = sign_pos(W);

  logic [M-1:0] a_mag_s;
  logic [M-1:0] b_mag_s;
  logic [M-1:0] mag_s;
  logic [M:0]   raw_s;
  logic         sign_s;

  // magnitude add/subtract, clamp on carry-out, normalise -0 to +0
  always_comb begin
    a_mag_s  = a[M-1:0];
    b_mag_s  = b[M-1:0];
    raw_s    = '0;
    sign_s   = 1'b0;
    mag_s    = '0;
    overflow = 1'b0;
    if (a[M] == b[M]) begin
      raw_s  = {1'b0, a_mag_s} + {1'b0, b_mag_s};
      sign_s = a[M];
    end else if (a_mag_s >= b_mag_s) begin
      raw_s  = {1'b0, a_mag_s - b_mag_s};
      sign_s = a[M];
    end else begin
      raw_s  = {1'b0, b_mag_s - a_mag_s};
      sign_s = b[M];
    end
    if (raw_s[M]) begin
      overflow = 1'b1;
      mag_s    = M'(max_mag(W));
    end else begin
      mag_s    = raw_s[M-1:0];
    end
    sum = {sign_s & (|mag_s), mag_s};
  end

endmodule

// File: rtl/conv_window_accum.sv
// Sums TAPS sign-magnitude tap products per window and hands the result out on valid/ready.
// Optional build macro CONV_ACC_RELU_EN: negative window results are presented as +0.
module conv_window_accum
  import conv_pkg::*;
#(
  parameter int TAPS  = TAPS_DEF,
  parameter int ACC_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             out_sat
);

  localparam int CNT_W = $clog2(TAPS + 1);
  localparam int SGN   = sign_pos(ACC_W);

  state_t             state_r;
  state_t             state_s;
  logic [CNT_W-1:0]   tap_cnt_r;
  logic [ACC_W-1:0]   acc_r;
  logic [ACC_W-1:0]   ext_s;
  logic [ACC_W-1:0]   sum_s;
  logic [ACC_W-1:0]   result_s;
  logic [ACC_W-1:0]   out_data_r;
  logic               ext_sign_s;
  logic               ovf_s;
  logic               sat_r;
  logic               out_sat_r;
  logic               accept_s;
  logic               last_s;
  logic               release_s;

  // 8'h80 (-0) enters the adder as +0
  assign ext_sign_s = in_data[PROD_SIGN] & (|in_data[PROD_SIGN-1:0]);
  assign ext_s      = {ext_sign_s, {(ACC_W-PROD_W){1'b0}}, in_data[PROD_SIGN-1:0]};

  assign accept_s   = in_valid && (state_r == ACCUM);
  assign last_s     = (tap_cnt_r == CNT_W'(TAPS - 1));
  assign release_s  = (state_r == HOLD) && out_ready;

  sm_add_sat #(.W(ACC_W)) u_add (
    .a        (acc_r),
    .b        (ext_s),
    .sum      (sum_s),
    .overflow (ovf_s)
  );

`ifdef CONV_ACC_RELU_EN
  // clip negative window results to +0 on the way out
  always_comb begin
    if (sum_s[SGN]) begin
      result_s = '0;
    end else begin
      result_s = sum_s;
    end
  end
`else
  assign result_s = sum_s;
`endif

  // next-state: leave ACCUM on the last tap, leave HOLD on the handshake
  always_comb begin
    state_s = state_r;
    case (state_r)
      ACCUM: begin
        if (accept_s && last_s) begin
          state_s = HOLD;
        end else begin
          state_s = ACCUM;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_s = ACCUM;
        end else begin
          state_s = HOLD;
        end
      end
      default: state_s = ACCUM;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ACCUM;
    end else begin
      state_r <= state_s;
    end
  end

  // accumulator, tap counter, sticky saturation and the held result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r      <= '0;
      tap_cnt_r  <= '0;
      sat_r      <= 1'b0;
      out_data_r <= '0;
      out_sat_r  <= 1'b0;
    end else if (accept_s) begin
      acc_r     <= sum_s;
      tap_cnt_r <= tap_cnt_r + CNT_W'(1);
      sat_r     <= sat_r | ovf_s;
      if (last_s) begin
        out_data_r <= result_s;
        out_sat_r  <= sat_r | ovf_s;
      end
    end else if (release_s) begin
      acc_r      <= '0;
      tap_cnt_r  <= '0;
      sat_r      <= 1'b0;
      out_data_r <= '0;
      out_sat_r  <= 1'b0;
    end
  end

  assign in_ready  = (state_r == ACCUM);
  assign out_valid = (state_r == HOLD);
  assign out_data  = out_data_r;
  assign out_sat   = out_sat_r;

endmodule
